// File: rtl/async_fifo_pkg.sv
// Shared defaults and helpers for the Gray-pointer FIFO.
//   DefaultDsize : default data width in bits
//   DefaultAsize : default address width (depth = 2^ASIZE)
//   bin2gray     : binary to reflected-Gray conversion (up to 32 bits)
package async_fifo_pkg;

  localparam int unsigned DefaultDsize = 8;
  localparam int unsigned DefaultAsize = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/async_fifo_mem.sv
// 2^ASIZE x DSIZE storage array for async_fifo.
//   clk   : write clock
//   we    : write enable, write happens on the rising edge
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read data at raddr
module async_fifo_mem
  import async_fifo_pkg::*;
#(
  parameter int unsigned DSIZE = DefaultDsize,
  parameter int unsigned ASIZE = DefaultAsize
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int unsigned Depth = 1 << ASIZE;

  // Contents are deliberately not reset.
  logic [DSIZE-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/async_fifo.sv
// Gray-pointer FIFO with first-word-fall-through read data and registered flags.
// Both sides share one clock; the pointer synchronizers are a build option.
//   clk    : clock, all state changes on the rising edge
//   rst    : synchronous active-high reset
//   winc   : push request, ignored while wfull
//   wdata  : push data
//   wfull  : FIFO full
//   rinc   : pop request, ignored while rempty
//   rdata  : head-of-queue data, valid while !rempty
//   rempty : FIFO empty
// Build option: define ASYNC_FIFO_SYNC_EN to route each opposite-side Gray pointer
// through a 2-flop synchronizer (flag release latency becomes 3 cycles).
module async_fifo
  import async_fifo_pkg::*;
#(
  parameter int unsigned DSIZE = DefaultDsize,
  parameter int unsigned ASIZE = DefaultAsize
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty
);

  localparam int unsigned PtrW = ASIZE + 1;

  logic [PtrW-1:0] wbin_q, wbin_d, wgray_q, wgray_d;
  logic [PtrW-1:0] rbin_q, rbin_d, rgray_q, rgray_d;
  logic            wfull_q, wfull_d, rempty_q, rempty_d;
  logic [PtrW-1:0] wgray_cmp, rgray_cmp;
  logic            push, pop;

  assign push = winc && !wfull_q;
  assign pop  = rinc && !rempty_q;

  always_comb begin
    wbin_d   = wbin_q + {{ASIZE{1'b0}}, push};
    rbin_d   = rbin_q + {{ASIZE{1'b0}}, pop};
    wgray_d  = PtrW'(bin2gray(32'(wbin_d)));
    rgray_d  = PtrW'(bin2gray(32'(rbin_d)));
    rempty_d = (rgray_d == wgray_cmp);
    // Full when the write pointer is one lap ahead: top two Gray bits differ, rest equal.
    wfull_d  = (wgray_d == {~rgray_cmp[ASIZE:ASIZE-1], rgray_cmp[ASIZE-2:0]});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      rbin_q   <= '0;
      rgray_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      rbin_q   <= rbin_d;
      rgray_q  <= rgray_d;
      wfull_q  <= wfull_d;
      rempty_q <= rempty_d;
    end
  end

`ifdef ASYNC_FIFO_SYNC_EN
  logic [PtrW-1:0] wq1_q, wq2_q, rq1_q, rq2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wq1_q <= '0;
      wq2_q <= '0;
      rq1_q <= '0;
      rq2_q <= '0;
    end else begin
      wq1_q <= wgray_q;
      wq2_q <= wq1_q;
      rq1_q <= rgray_q;
      rq2_q <= rq1_q;
    end
  end

  assign wgray_cmp = wq2_q;
  assign rgray_cmp = rq2_q;
`else
  assign wgray_cmp = wgray_q;
  assign rgray_cmp = rgray_q;
`endif

  async_fifo_mem #(
    .DSIZE(DSIZE),
    .ASIZE(ASIZE)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wbin_q[ASIZE-1:0]),
    .wdata(wdata),
    .raddr(rbin_q[ASIZE-1:0]),
    .rdata(rdata)
  );

  assign wfull  = wfull_q;
  assign rempty = rempty_q;

endmodule

// File: tb/tb_async_fifo.sv
// Scoreboard bench for async_fifo (default 8x16). Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_async_fifo;

  localparam int Depth = 16;
`ifdef ASYNC_FIFO_SYNC_EN
  localparam int Lat = 3;
`else
  localparam int Lat = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       winc;
  logic [7:0] wdata;
  logic       wfull;
  logic       rinc;
  logic [7:0] rdata;
  logic       rempty;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  async_fifo #(
    .DSIZE(8),
    .ASIZE(4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .winc  (winc),
    .wdata (wdata),
    .wfull (wfull),
    .rinc  (rinc),
    .rdata (rdata),
    .rempty(rempty)
  );

  // One cycle of stimulus. On return the outputs still show the state before
  // this cycle's rising edge.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r, input string tag);
    int         n;
    logic [7:0] exp;
    @(negedge clk);
    winc  = w;
    wdata = d;
    rinc  = r;
    n = sb.size();
    if (r && n > 0) begin
      exp = sb.pop_front();
      checks++;
      if (rdata !== exp) begin
        errors++;
        $display("FAIL %s rdata: got %02h expected %02h", tag, rdata, exp);
      end
    end
    if (w && n < Depth) sb.push_back(d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      winc = 1'b0;
      rinc = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    winc = 1'b0;
    rinc = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (rempty !== 1'b1 || wfull !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: rempty=%b wfull=%b expected 1 0", rempty, wfull);
    end
    cycle(1'b0, 8'h00, 1'b1, "pop_empty");
    idle(1);
    checks++;
    if (rempty !== 1'b1 || wfull !== 1'b0) begin
      errors++;
      $display("FAIL pop_empty_flags: rempty=%b wfull=%b expected 1 0", rempty, wfull);
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, "midrst_push");
    idle(Lat + 1);
    checks++;
    if (rempty !== 1'b0) begin
      errors++;
      $display("FAIL midrst_nonempty: rempty=%b expected 0", rempty);
    end
    do_reset();
    idle(Lat + 1);
    checks++;
    if (rempty !== 1'b1 || wfull !== 1'b0) begin
      errors++;
      $display("FAIL midrst_cleared: rempty=%b wfull=%b expected 1 0", rempty, wfull);
    end
  endtask

  task automatic test_order();
    do_reset();
    for (int i = 0; i < Depth; i++) begin
      cycle(1'b1, 8'($urandom_range(199, 0)), 1'b0, "order_push");
      cycle(1'b0, 8'h00, 1'b0, "order_gap");
    end
    idle(Lat + 1);
    checks++;
    if (wfull !== 1'b1 || rempty !== 1'b0) begin
      errors++;
      $display("FAIL order_filled: wfull=%b rempty=%b expected 1 0", wfull, rempty);
    end
    for (int i = 0; i < Depth - 1; i++) cycle(1'b0, 8'h00, 1'b1, "order_pop");
    idle(1);
    checks++;
    if (rempty !== 1'b0) begin
      errors++;
      $display("FAIL order_15th: rempty=%b expected 0", rempty);
    end
    cycle(1'b0, 8'h00, 1'b1, "order_pop16");
    idle(1);
    checks++;
    if (rempty !== 1'b1) begin
      errors++;
      $display("FAIL order_16th: rempty=%b expected 1", rempty);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < Depth; i++) cycle(1'b1, 8'(i), 1'b0, "full_push");
    cycle(1'b1, 8'h10, 1'b0, "full_push17");
    checks++;
    if (wfull !== 1'b1) begin
      errors++;
      $display("FAIL full_at_16th_edge: wfull=%b expected 1", wfull);
    end
    idle(Lat + 1);
    checks++;
    if (wfull !== 1'b1) begin
      errors++;
      $display("FAIL full_held: wfull=%b expected 1", wfull);
    end
    for (int i = 0; i < Depth; i++) cycle(1'b0, 8'h00, 1'b1, "full_pop");
    idle(1);
    checks++;
    if (rempty !== 1'b1) begin
      errors++;
      $display("FAIL full_drained: rempty=%b expected 1 (0x10 should be dropped)", rempty);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int round = 0; round < 2; round++) begin
      for (int i = 0; i < Depth; i++) begin
        cycle(1'b1, 8'($urandom_range(255, 0)), 1'b0, "wrap_push");
        if (i == Depth - 1) begin
          checks++;
          if (wfull !== 1'b0) begin
            errors++;
            $display("FAIL wrap_15_notfull r%0d: wfull=%b expected 0", round, wfull);
          end
        end
      end
      idle(1);
      checks++;
      if (wfull !== 1'b1) begin
        errors++;
        $display("FAIL wrap_full r%0d: wfull=%b expected 1", round, wfull);
      end
      idle(Lat);
      for (int i = 0; i < Depth; i++) cycle(1'b0, 8'h00, 1'b1, "wrap_pop");
      idle(1);
      checks++;
      if (rempty !== 1'b1 || wfull !== 1'b0) begin
        errors++;
        $display("FAIL wrap_empty r%0d: rempty=%b wfull=%b expected 1 0", round, rempty, wfull);
      end
      idle(Lat);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, "simul_pre");
    idle(Lat + 1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 8'($urandom_range(255, 0)), 1'b1, "simul_rw");
      checks++;
      if (rempty !== 1'b0 || wfull !== 1'b0) begin
        errors++;
        $display("FAIL simul_flags cyc%0d: rempty=%b wfull=%b expected 0 0", i, rempty, wfull);
      end
    end
    idle(Lat + 1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, "simul_pop");
    idle(1);
    checks++;
    if (rempty !== 1'b0) begin
      errors++;
      $display("FAIL simul_occ4: rempty=%b expected 0", rempty);
    end
    cycle(1'b0, 8'h00, 1'b1, "simul_pop5");
    idle(1);
    checks++;
    if (rempty !== 1'b1) begin
      errors++;
      $display("FAIL simul_occ5: rempty=%b expected 1", rempty);
    end
  endtask

  task automatic test_latency();
    int edges;
    do_reset();
    idle(Lat + 1);
    cycle(1'b1, 8'hA5, 1'b0, "lat_push");
    edges = 0;
    for (int n = 1; n <= 10; n++) begin
      idle(1);
      edges = n - 1;
      if (rempty == 1'b0) break;
      edges = 99;
    end
    checks++;
    if (edges != Lat) begin
      errors++;
      $display("FAIL lat_rempty: release after %0d edges expected %0d", edges, Lat);
    end
    for (int i = 0; i < Depth - 1; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0, "lat_fill");
    idle(Lat + 1);
    cycle(1'b0, 8'h00, 1'b1, "lat_pop_head");
    edges = 0;
    for (int n = 1; n <= 10; n++) begin
      idle(1);
      edges = n - 1;
      if (wfull == 1'b0) break;
      edges = 99;
    end
    checks++;
    if (edges != Lat) begin
      errors++;
      $display("FAIL lat_wfull: release after %0d edges expected %0d", edges, Lat);
    end
    for (int i = 0; i < Depth - 1; i++) cycle(1'b0, 8'h00, 1'b1, "lat_drain");
    idle(1);
    checks++;
    if (rempty !== 1'b1) begin
      errors++;
      $display("FAIL lat_drained: rempty=%b expected 1", rempty);
    end
  endtask

  initial begin
    rst   = 1'b1;
    winc  = 1'b0;
    rinc  = 1'b0;
    wdata = 8'h00;
    test_reset();
    test_order();
    test_full();
    test_wrap();
    test_simultaneous();
    test_latency();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
